ntt_addr_ctrl: RTL and testbench

- Controller and address generator that drives the 4-port coefficient RAM (256 x 16-bit, shared read/write address per port, single `we`) for an in-place radix-2 NTT.
- Per group it issues two butterflies (A1/B1, A2/B2) as a read phase, waits for the butterfly pipeline, then writes back at the same addresses.
- Also emits twiddle-ROM indices and a read-data-valid strobe for the butterfly units.

---
 rtl/ntt_addr_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ntt_addr_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_addr_ctrl.sv
// ntt_addr_ctrl: sequencer and address generator for an in-place radix-2 NTT
// over a 4-port coefficient RAM. Each group runs read, butterfly wait and
// write-back for two butterflies. It also drives twiddle ROM indices and a
// read-data-valid strobe.
// Optional build macro: NTT_ADDR_CTRL_INVERSE_EN adds the 'inv' input, which
// selects Gentleman-Sande ordering for a run.
//
// state  | meaning
// IDLE   | waiting for start
// RD     | addresses/twiddles for (stage, group) presented, RAM read issued
// WAIT   | butterfly pipeline latency, read data valid in first cycle
// WR     | write-back at the same addresses, advance group/stage
// DONE   | one-cycle completion pulse, addresses cleared
module ntt_addr_ctrl #(
    parameter int AWID   = 8,
    parameter int BF_LAT = 4,
    parameter int SW     = (AWID > 1) ? $clog2(AWID) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
`ifdef NTT_ADDR_CTRL_INVERSE_EN
    input  logic            inv,
`endif
    output logic            busy,
    output logic            done,
    output logic [AWID-1:0] A1radd,
    output logic [AWID-1:0] B1radd,
    output logic [AWID-1:0] A2radd,
    output logic [AWID-1:0] B2radd,
    output logic            we,
    output logic            rd_valid,
    output logic [AWID-1:0] tw1_idx,
    output logic [AWID-1:0] tw2_idx,
    output logic [SW-1:0]   stage
);

    localparam int STAGES = AWID;
    localparam int GW     = AWID - 2;
    localparam int CW     = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]      state;
    logic [GW-1:0]   g_r;
    logic [GW-1:0]   ng;
    logic [SW-1:0]   ns;
    logic [CW-1:0]   cnt;
    logic            inv_sel;
    logic            last_grp;
    logic            last_stg;
    logic [AWID-1:0] n_a1, n_b1, n_a2, n_b2, n_tw1, n_tw2;
    int              s_i, k0, k1, lh;

`ifdef NTT_ADDR_CTRL_INVERSE_EN
    logic inv_r;
    // inv is only looked at on the accepted start; afterwards the latched copy rules
    assign inv_sel = (state == S_IDLE) ? inv : inv_r;
`else
    assign inv_sel = 1'b0;
`endif

    assign last_grp = (g_r == {GW{1'b1}});
    assign last_stg = (stage == SW'(STAGES - 1));

    // Butterfly partner index: insert a zero at bit lh, optionally set it for the upper leg
    function automatic logic [AWID-1:0] j_addr(input int k, input int sh, input bit hi);
        int v;
        v = (((k >> sh) << (sh + 1)) | (k & ((1 << sh) - 1))) + (hi ? (1 << sh) : 0);
        return AWID'(v);
    endfunction

    // Twiddle index, forward (Cooley-Tukey) or inverse (Gentleman-Sande) order
    function automatic logic [AWID-1:0] tw_calc(input int k, input int s, input logic iv);
        int v;
        if (iv)
            v = (2 << (AWID - 1 - s)) - 1 - (k >> s);
        else
            v = (1 << s) + (k >> (AWID - 1 - s));
        return AWID'(v);
    endfunction

    // Next (stage, group) to be presented: (0,0) from IDLE, successor from WR
    always_comb begin
        ns = '0;
        ng = '0;
        if (state == S_WR) begin
            if (last_grp) begin
                ns = stage + 1'b1;
                ng = '0;
            end else begin
                ns = stage;
                ng = g_r + 1'b1;
            end
        end
    end

    // Addresses and twiddles for the next group, registered on state transitions
    always_comb begin
        s_i   = int'(ns);
        k0    = 2 * int'(ng);
        k1    = k0 + 1;
        lh    = inv_sel ? s_i : (AWID - 1 - s_i);
        n_a1  = j_addr(k0, lh, 1'b0);
        n_b1  = j_addr(k0, lh, 1'b1);
        n_a2  = j_addr(k1, lh, 1'b0);
        n_b2  = j_addr(k1, lh, 1'b1);
        n_tw1 = tw_calc(k0, s_i, inv_sel);
        n_tw2 = tw_calc(k1, s_i, inv_sel);
    end

    // Sequencer: state, counters and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            stage    <= '0;
            g_r      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            we       <= 1'b0;
            rd_valid <= 1'b0;
            A1radd   <= '0;
            B1radd   <= '0;
            A2radd   <= '0;
            B2radd   <= '0;
            tw1_idx  <= '0;
            tw2_idx  <= '0;
`ifdef NTT_ADDR_CTRL_INVERSE_EN
            inv_r    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RD;
                        stage   <= '0;
                        g_r     <= '0;
                        busy    <= 1'b1;
                        A1radd  <= n_a1;
                        B1radd  <= n_b1;
                        A2radd  <= n_a2;
                        B2radd  <= n_b2;
                        tw1_idx <= n_tw1;
                        tw2_idx <= n_tw2;
`ifdef NTT_ADDR_CTRL_INVERSE_EN
                        inv_r   <= inv;
`endif
                    end
                end
                S_RD: begin
                    state    <= S_WAIT;
                    cnt      <= CW'(BF_LAT - 1);
                    rd_valid <= 1'b1;
                end
                S_WAIT: begin
                    rd_valid <= 1'b0;
                    if (cnt == '0) begin
                        state <= S_WR;
                        we    <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WR: begin
                    we <= 1'b0;
                    if (last_grp && last_stg) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        stage   <= '0;
                        g_r     <= '0;
                        A1radd  <= '0;
                        B1radd  <= '0;
                        A2radd  <= '0;
                        B2radd  <= '0;
                        tw1_idx <= '0;
                        tw2_idx <= '0;
                    end else begin
                        state   <= S_RD;
                        stage   <= ns;
                        g_r     <= ng;
                        A1radd  <= n_a1;
                        B1radd  <= n_b1;
                        A2radd  <= n_a2;
                        B2radd  <= n_b2;
                        tw1_idx <= n_tw1;
                        tw2_idx <= n_tw2;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_addr_ctrl.sv
// Scoreboard bench for ntt_addr_ctrl: stimulus pushes expected rd_valid / we /
// done events, a negedge monitor pops and compares each event the DUT shows.
module tb_ntt_addr_ctrl;

    localparam int AWID   = 8;
    localparam int BF_LAT = 4;
    localparam int PER    = 2 + BF_LAT;
    localparam int NGRP   = 8 * 64;
    localparam int TDONE  = NGRP * PER + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
`ifdef NTT_ADDR_CTRL_INVERSE_EN
    logic       inv = 1'b0;
`endif
    logic       busy, done, we, rd_valid;
    logic [7:0] A1radd, B1radd, A2radd, B2radd, tw1_idx, tw2_idx;
    logic [2:0] stage;

    always #5 clk = ~clk;

    ntt_addr_ctrl #(.AWID(AWID), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef NTT_ADDR_CTRL_INVERSE_EN
        .inv(inv),
`endif
        .busy(busy), .done(done),
        .A1radd(A1radd), .B1radd(B1radd), .A2radd(A2radd), .B2radd(B2radd),
        .we(we), .rd_valid(rd_valid),
        .tw1_idx(tw1_idx), .tw2_idx(tw2_idx), .stage(stage)
    );

    // kind: 1 = rd_valid, 2 = we, 4 = done
    typedef struct {
        int   kind;
        int   cyc;
        logic bsy;
        bit   chk;
        int   stg;
        int   a1, b1, a2, b2, t1, t2;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    int   base_edge = 0;
    int   wr_cnt[256];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int cur_cyc();
        return edge_cnt - base_edge + 1;
    endfunction

    // Monitor: one pop per DUT event
    always @(negedge clk) begin
        int   obs;
        exp_t e;
        if (!rst && (rd_valid || we || done)) begin
            obs = int'({done, we, rd_valid});
            if (we) begin
                wr_cnt[A1radd]++;
                wr_cnt[B1radd]++;
                wr_cnt[A2radd]++;
                wr_cnt[B2radd]++;
            end
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d kind=%0d", cur_cyc(), obs);
            end else begin
                e = sbq.pop_front();
                if (obs != e.kind || cur_cyc() != e.cyc || busy !== e.bsy) begin
                    failures++;
                    $display("FAIL event got kind=%0d cyc=%0d busy=%b expected kind=%0d cyc=%0d busy=%b",
                             obs, cur_cyc(), busy, e.kind, e.cyc, e.bsy);
                end
                if (e.chk) begin
                    checks++;
                    if (int'(A1radd) != e.a1 || int'(B1radd) != e.b1 ||
                        int'(A2radd) != e.a2 || int'(B2radd) != e.b2 ||
                        (e.kind != 4 && (int'(tw1_idx) != e.t1 || int'(tw2_idx) != e.t2 ||
                                         int'(stage) != e.stg))) begin
                        failures++;
                        $display("FAIL addr cyc=%0d got A1=%0d B1=%0d A2=%0d B2=%0d tw1=%0d tw2=%0d stage=%0d expected A1=%0d B1=%0d A2=%0d B2=%0d tw1=%0d tw2=%0d stage=%0d",
                                 cur_cyc(), A1radd, B1radd, A2radd, B2radd, tw1_idx, tw2_idx, stage,
                                 e.a1, e.b1, e.a2, e.b2, e.t1, e.t2, e.stg);
                    end
                end
            end
        end
    end

    task automatic push_evt(input int kind, input int cyc, input logic bsy, input bit chk,
                            input int stg, input int a1, input int b1, input int a2,
                            input int b2, input int t1, input int t2);
        exp_t e;
        e.kind = kind; e.cyc = cyc; e.bsy = bsy; e.chk = chk; e.stg = stg;
        e.a1 = a1; e.b1 = b1; e.a2 = a2; e.b2 = b2; e.t1 = t1; e.t2 = t2;
        sbq.push_back(e);
    endtask

    // Group i: RD in cycle 1+PER*i, rd_valid one cycle later, we in the last cycle
    task automatic push_group(input int i, input bit chk, input int a1, input int b1,
                              input int a2, input int b2, input int t1, input int t2);
        push_evt(1, 2 + PER * i, 1'b1, chk, i / 64, a1, b1, a2, b2, t1, t2);
        push_evt(2, PER + PER * i, 1'b1, chk, i / 64, a1, b1, a2, b2, t1, t2);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        base_edge = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({busy, done, we, rd_valid, A1radd, B1radd, A2radd, B2radd, tw1_idx, tw2_idx, stage} !== '0) begin
            failures++;
            $display("FAIL %s outputs=%h required all zero", name,
                     {busy, done, we, rd_valid, A1radd, B1radd, A2radd, B2radd, tw1_idx, tw2_idx, stage});
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL %s pending=%0d required 0", name, sbq.size());
        end
    endtask

    // Full transform; table rows are {group, A1, B1, A2, B2, tw1, tw2}
    task automatic run_full(input bit inverse);
        int fwd[5][7] = '{'{0, 0, 128, 1, 129, 1, 1},
                          '{1, 2, 130, 3, 131, 1, 1},
                          '{64, 0, 64, 1, 65, 2, 2},
                          '{448, 0, 1, 2, 3, 128, 129},
                          '{511, 252, 253, 254, 255, 254, 255}};
        int ivt[2][7] = '{'{0, 0, 1, 2, 3, 255, 254},
                          '{448, 0, 128, 1, 129, 1, 1}};
        int n;
        int bad;
        bit hit;
        foreach (wr_cnt[a]) wr_cnt[a] = 0;
        for (int i = 0; i < NGRP; i++) begin
            hit = 1'b0;
            if (!inverse) begin
                for (int r = 0; r < 5; r++)
                    if (fwd[r][0] == i) begin
                        push_group(i, 1'b1, fwd[r][1], fwd[r][2], fwd[r][3], fwd[r][4], fwd[r][5], fwd[r][6]);
                        hit = 1'b1;
                    end
            end else begin
                for (int r = 0; r < 2; r++)
                    if (ivt[r][0] == i) begin
                        push_group(i, 1'b1, ivt[r][1], ivt[r][2], ivt[r][3], ivt[r][4], ivt[r][5], ivt[r][6]);
                        hit = 1'b1;
                    end
            end
            if (!hit) push_group(i, 1'b0, 0, 0, 0, 0, 0, 0);
        end
        push_evt(4, TDONE, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0);
        do_start();
`ifdef NTT_ADDR_CTRL_INVERSE_EN
        inv = 1'b0;
`endif
        while (cur_cyc() < 100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_drained("run_timeout");
        sbq.delete();
        repeat (10) @(negedge clk);
        bad = 0;
        foreach (wr_cnt[a]) if (wr_cnt[a] != 8) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL write_count addresses_not_8=%0d required 0 (addr0 count=%0d)", bad, wr_cnt[0]);
        end
    endtask

    initial begin
        // async reset with no clock edge
        #2 rst = 1'b1;
        #1 check_zero("reset_async");
        #19 rst = 1'b0;
        repeat (2) @(negedge clk);

        run_full(1'b0);

        // reset at cycle 500 mid-run: no done afterwards
        for (int i = 0; i < 90; i++) begin
            if (2 + PER * i <= 500) push_evt(1, 2 + PER * i, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
            if (PER + PER * i <= 500) push_evt(2, PER + PER * i, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        end
        do_start();
        while (cur_cyc() < 500 && cur_cyc() > 0) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("reset_midrun");
        check_drained("events_before_reset");
        sbq.delete();
        #10 rst = 1'b0;
        repeat (3200) @(negedge clk);

        // fresh start reproduces the first groups, then abort again
        push_group(0, 1'b1, 0, 128, 1, 129, 1, 1);
        push_group(1, 1'b1, 2, 130, 3, 131, 1, 1);
        do_start();
        while (cur_cyc() < 13 && cur_cyc() > 0) @(negedge clk);
        check_drained("fresh_start");
        #2 rst = 1'b1;
        #1 check_zero("reset_after_fresh");
        sbq.delete();
        #10 rst = 1'b0;
        repeat (20) @(negedge clk);

`ifdef NTT_ADDR_CTRL_INVERSE_EN
        inv = 1'b1;
        run_full(1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
